// File: rtl/johnson_phase_monitor.sv
// Johnson phase monitor: decodes a 4-bit Johnson code to phase idx/one-hot, checks legality and step order, tracks lock.
// Latency: every output is registered one cycle after the in_valid sample.
// Backpressure: none; a sample is taken every cycle in_valid is high, and outputs hold while it is low.
module johnson_phase_monitor #(
  parameter int LOCK_COUNT = 4,
  parameter int REV_W      = 8,
  parameter int ERR_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       in_code,
  input  logic             clr_counts,
  output logic             out_valid,
  output logic [2:0]       phase_idx,
  output logic [7:0]       phase_onehot,
  output logic             locked,
  output logic             illegal_code,
  output logic             bad_step,
  output logic [REV_W-1:0] rev_count,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_STEPS = 4'(LOCK_COUNT);

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_step;
  logic [2:0]       r_prev;
  logic             r_out_valid;
  logic [2:0]       r_phase_idx;
  logic [7:0]       r_phase_onehot;
  logic             r_illegal;
  logic             r_bad;
  logic [REV_W-1:0] r_rev;
  logic [ERR_W-1:0] r_err;

  logic       w_legal;
  logic [2:0] w_phase;
  logic       w_hold;
  logic       w_adv;
  logic       w_sample_legal;
  logic       w_ill_evt;
  logic       w_checked;
  logic       w_bad_evt;
  logic       w_adv_evt;
  logic       w_lock_reach;
  logic       w_rev_evt;

  // Decode the Johnson code to a phase; the 8 non-Johnson patterns are illegal.
  always_comb begin
    w_legal = 1'b1;
    w_phase = 3'd0;
    case (in_code)
      4'b0000: w_phase = 3'd0;
      4'b1000: w_phase = 3'd1;
      4'b1100: w_phase = 3'd2;
      4'b1110: w_phase = 3'd3;
      4'b1111: w_phase = 3'd4;
      4'b0111: w_phase = 3'd5;
      4'b0011: w_phase = 3'd6;
      4'b0001: w_phase = 3'd7;
      default: w_legal = 1'b0;
    endcase
  end

  // Step classification against the last legal phase; no step check while unlocked.
  assign w_hold         = (w_phase == r_prev);
  assign w_adv          = (w_phase == 3'(r_prev + 3'd1));
  assign w_sample_legal = in_valid & w_legal;
  assign w_ill_evt      = in_valid & ~w_legal;
  assign w_checked      = w_sample_legal & (r_state != ST_UNLOCKED);
  assign w_bad_evt      = w_checked & ~w_hold & ~w_adv;
  assign w_adv_evt      = w_checked & w_adv;
  assign w_lock_reach   = (r_state == ST_ACQUIRE) & w_adv_evt & (4'(r_step + 4'd1) == LOCK_STEPS);
  assign w_rev_evt      = (r_state == ST_LOCKED) & w_adv_evt & (r_prev == 3'd7);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_UNLOCKED;
    else       r_state <= w_next;
  end

  // FSM next state: any illegal code or bad step drops back to UNLOCKED.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_UNLOCKED: if (w_sample_legal) w_next = ST_ACQUIRE;
      ST_ACQUIRE: begin
        if (w_ill_evt || w_bad_evt) w_next = ST_UNLOCKED;
        else if (w_lock_reach)      w_next = ST_LOCKED;
      end
      ST_LOCKED:   if (w_ill_evt || w_bad_evt) w_next = ST_UNLOCKED;
      default:     w_next = ST_UNLOCKED;
    endcase
  end

  // FSM output: lock flag follows the registered state.
  always_comb begin
    locked = (r_state == ST_LOCKED);
  end

  // Step counter only lives in ACQUIRE; it is zero on entry because it is cleared everywhere else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_step <= 4'd0;
    else if (w_next != ST_ACQUIRE) r_step <= 4'd0;
    else if (w_adv_evt)          r_step <= r_step + 4'd1;
  end

  // Registered phase outputs and event pulses; phase_idx keeps its value across illegal samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid    <= 1'b0;
      r_phase_idx    <= 3'd0;
      r_phase_onehot <= 8'h00;
      r_prev         <= 3'd0;
      r_illegal      <= 1'b0;
      r_bad          <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      r_illegal   <= w_ill_evt;
      r_bad       <= w_bad_evt;
      if (w_sample_legal) begin
        r_phase_idx    <= w_phase;
        r_phase_onehot <= 8'h01 << w_phase;
        r_prev         <= w_phase;
      end else if (w_ill_evt) begin
        r_phase_onehot <= 8'h00;
      end
    end
  end

  // Revolution (wrapping) and error (saturating) counters; a clear beats a coincident event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rev <= '0;
      r_err <= '0;
    end else if (clr_counts) begin
      r_rev <= '0;
      r_err <= '0;
    end else begin
      if (w_rev_evt) r_rev <= r_rev + 1'b1;
      if ((w_ill_evt || w_bad_evt) && (r_err != {ERR_W{1'b1}})) r_err <= r_err + 1'b1;
    end
  end

  assign out_valid    = r_out_valid;
  assign phase_idx    = r_phase_idx;
  assign phase_onehot = r_phase_onehot;
  assign illegal_code = r_illegal;
  assign bad_step     = r_bad;
  assign rev_count    = r_rev;
  assign err_count    = r_err;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Scoreboard bench for johnson_phase_monitor with a phase-arithmetic reference model.
module tb_johnson_phase_monitor;

  localparam int LC = 4;

  typedef struct packed {
    logic       ov;
    logic [2:0] idx;
    logic [7:0] oh;
    logic       lk;
    logic       il;
    logic       bd;
    logic [7:0] rev;
    logic [3:0] err;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_code = 4'd0;
  logic       clr_counts = 1'b0;
  logic       out_valid;
  logic [2:0] phase_idx;
  logic [7:0] phase_onehot;
  logic       locked;
  logic       illegal_code;
  logic       bad_step;
  logic [7:0] rev_count;
  logic [3:0] err_count;

  johnson_phase_monitor #(.LOCK_COUNT(LC), .REV_W(8), .ERR_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_code(in_code), .clr_counts(clr_counts),
    .out_valid(out_valid), .phase_idx(phase_idx), .phase_onehot(phase_onehot), .locked(locked),
    .illegal_code(illegal_code), .bad_step(bad_step), .rev_count(rev_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  obs_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  // Reference model state: mode 0=unlocked, 1=acquiring, 2=locked.
  int         m_mode, m_prev, m_steps, m_rev, m_err, m_idx;
  logic [7:0] m_oh;
  int         legal_tab[8] = '{0, 8, 12, 14, 15, 7, 3, 1};
  int         cur = 0;

  function automatic int phase_of(input logic [3:0] c);
    for (int i = 0; i < 8; i++) if (legal_tab[i] == int'(c)) return i;
    return -1;
  endfunction

  function automatic logic [3:0] code_of(input int p);
    return 4'(legal_tab[p % 8]);
  endfunction

  function automatic obs_t actual();
    obs_t a;
    a.ov = out_valid; a.idx = phase_idx; a.oh = phase_onehot; a.lk = locked;
    a.il = illegal_code; a.bd = bad_step; a.rev = rev_count; a.err = err_count;
    return a;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_steps = 0; m_rev = 0; m_err = 0; m_idx = 0; m_oh = 8'h00;
  endtask

  task automatic check_direct(input string name, input obs_t exp);
    obs_t a;
    a = actual();
    n_cmp++;
    if (a !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, a, exp);
    end
  endtask

  // Drive one sample, let the DUT take it, then push the model's prediction.
  task automatic cyc(input logic v, input logic [3:0] c, input logic cl);
    obs_t e;
    int   p, d, ev, rv;
    in_valid = v; in_code = c; clr_counts = cl;
    @(posedge clk);
    e = '0; ev = 0; rv = 0;
    if (v) begin
      p = phase_of(c);
      if (p < 0) begin
        e.il = 1'b1; ev = 1; m_oh = 8'h00; m_mode = 0;
      end else begin
        m_oh = 8'(1 << p); m_idx = p;
        if (m_mode == 0) begin
          m_mode = 1; m_steps = 0;
        end else begin
          d = (p - m_prev + 8) % 8;
          if (d == 1) begin
            if (m_mode == 1) begin
              m_steps++;
              if (m_steps == LC) m_mode = 2;
            end else if (m_prev == 7) begin
              rv = 1;
            end
          end else if (d != 0) begin
            e.bd = 1'b1; ev = 1; m_mode = 0;
          end
        end
        m_prev = p;
      end
    end
    if (cl) begin
      m_rev = 0; m_err = 0;
    end else begin
      m_rev = (m_rev + rv) % 256;
      m_err = (m_err + ev > 15) ? 15 : m_err + ev;
    end
    e.ov = v; e.idx = 3'(m_idx); e.oh = m_oh; e.lk = (m_mode == 2);
    e.rev = 8'(m_rev); e.err = 4'(m_err);
    q.push_back(e);
    #1;
  endtask

  task automatic adv();
    cur = (cur + 1) % 8;
    cyc(1'b1, code_of(cur), 1'b0);
  endtask

  function automatic logic [3:0] rand_illegal();
    logic [3:0] c;
    c = 4'($urandom_range(0, 15));
    while (phase_of(c) >= 0) c = 4'($urandom_range(0, 15));
    return c;
  endfunction

  // Monitor: compares the DUT against the oldest prediction each cycle one is pending.
  always @(negedge clk) begin
    obs_t e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = actual();
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got ov=%b idx=%0d oh=%h lk=%b il=%b bd=%b rev=%0d err=%0d, expected ov=%b idx=%0d oh=%h lk=%b il=%b bd=%b rev=%0d err=%0d",
                 $time, a.ov, a.idx, a.oh, a.lk, a.il, a.bd, a.rev, a.err,
                 e.ov, e.idx, e.oh, e.lk, e.il, e.bd, e.rev, e.err);
      end
    end
  end

  initial begin
    int r;
    model_reset();
    #3;
    check_direct("reset_state", '0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Acquire from phase 0 and lock after the LC-th advance.
    cur = 0;
    cyc(1'b1, code_of(0), 1'b0);
    for (int i = 0; i < 9; i++) adv();

    // Three revolutions with in_valid toggling; invalid cycles carry junk codes.
    for (int i = 0; i < 24; i++) begin
      adv();
      cyc(1'b0, 4'($urandom_range(0, 15)), 1'b0);
    end
    cyc(1'b0, 4'd0, 1'b1);

    // Illegal code while locked at phase 2, then resume.
    for (int k = 0; k < 8 && cur != 2; k++) adv();
    cyc(1'b1, 4'b1010, 1'b0);
    for (int i = 0; i < 8; i++) adv();

    // Bad step while locked at phase 3, then repeated 1100.
    for (int k = 0; k < 8 && cur != 3; k++) adv();
    cyc(1'b1, 4'b0011, 1'b0);
    cyc(1'b1, 4'b1100, 1'b0);
    cyc(1'b1, 4'b1100, 1'b0);
    cur = 2;

    // Error counter saturation, then a clear coincident with an error.
    for (int i = 0; i < 20; i++) cyc(1'b1, rand_illegal(), 1'b0);
    cyc(1'b1, rand_illegal(), 1'b1);
    cyc(1'b1, code_of(cur), 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 3) == 0) begin
        cyc(1'b0, 4'($urandom_range(0, 15)), ($urandom_range(0, 49) == 0));
      end else if (r < 65) begin
        cur = (cur + 1) % 8;
        cyc(1'b1, code_of(cur), ($urandom_range(0, 49) == 0));
      end else if (r < 80) begin
        cyc(1'b1, code_of(cur), ($urandom_range(0, 49) == 0));
      end else if (r < 90) begin
        cyc(1'b1, rand_illegal(), ($urandom_range(0, 49) == 0));
      end else begin
        cur = $urandom_range(0, 7);
        cyc(1'b1, code_of(cur), ($urandom_range(0, 49) == 0));
      end
    end

    // Lock again, then assert reset mid-cycle, away from any clock edge.
    for (int i = 0; i < 12; i++) adv();
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check_direct("async_reset_no_edge", '0);
    in_valid = 1'b1; in_code = code_of(cur + 1);
    @(posedge clk); #1;
    check_direct("reset_held_over_edge", '0);
    model_reset();
    reset = 1'b0;

    // First samples after reset start from UNLOCKED.
    for (int i = 0; i < 20; i++) adv();
    cyc(1'b0, 4'd0, 1'b0);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/johnson_phase_monitor.md
Name: johnson_phase_monitor

Overview:
- Downstream consumer of the 4-bit Johnson ring counter output.
- Registers each sampled Johnson code, decodes it to a phase index and an 8-bit one-hot phase, and checks code legality and step order.
- Tracks lock status through a small FSM and counts completed revolutions and errors.
- Feeds phase-sequenced control logic and a status register.

Parameters:
- LOCK_COUNT, 4, number of consecutive legal advancing steps needed to go from ACQUIRE to LOCKED (range 1..15).
- REV_W, 8, width of the revolution counter.
- ERR_W, 4, width of the error counter.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_code is sampled this cycle.
- in_code  input  4  Johnson code, bit3 is the MSB stage.
- clr_counts  input  1  synchronous clear of rev_count and err_count.
- out_valid  output  1  phase outputs are updated; a registered copy of in_valid.
- phase_idx  output  3  decoded phase 0..7.
- phase_onehot  output  8  bit phase_idx set; all zero on an illegal code.
- locked  output  1  FSM is in LOCKED.
- illegal_code  output  1  one-cycle pulse: the sampled code is not one of the 8 legal codes.
- bad_step  output  1  one-cycle pulse: a legal code arrived that is neither the same phase nor the next phase.
- rev_count  output  REV_W  completed revolutions, wraps modulo 2^REV_W.
- err_count  output  ERR_W  illegal_code plus bad_step events, saturates at all-ones.

Behaviour:
- Decode map (in_code -> phase):
  - 0000->0, 1000->1, 1100->2, 1110->3
  - 1111->4, 0111->5, 0011->6, 0001->7
  - The other 8 codes are illegal.
- Latency: all outputs register one cycle after the in_valid sample. With in_valid=0, out_valid=0 the next cycle, and phase_idx, phase_onehot, locked and the counters hold. illegal_code and bad_step are 0.
- Reset values:
  - out_valid=0, phase_idx=0, phase_onehot=8'h00, locked=0.
  - illegal_code=0, bad_step=0, rev_count=0, err_count=0.
  - FSM=UNLOCKED, internal prev_phase=0, step counter=0.
- Step classification, for a valid legal sample against prev_phase:
  - HOLD: phase equals prev_phase. Legal; the step counter does not advance.
  - ADVANCE: phase equals (prev_phase+1) mod 8.
  - BAD: anything else.
  - prev_phase updates only on legal samples.
- FSM:
  - UNLOCKED: first legal sample loads prev_phase and moves to ACQUIRE with step counter=0. No step check is made on this sample. An illegal sample stays in UNLOCKED.
  - ACQUIRE:
    - ADVANCE increments the step counter; on reaching LOCK_COUNT, go to LOCKED.
    - HOLD: no change.
    - BAD: pulse bad_step, go to UNLOCKED.
    - Illegal: pulse illegal_code, go to UNLOCKED.
  - LOCKED:
    - ADVANCE/HOLD: stay.
    - BAD: pulse bad_step, go to UNLOCKED.
    - Illegal: pulse illegal_code, go to UNLOCKED.
  - locked is high in the cycle after the transition into LOCKED.
- illegal_code is flagged in every state, including UNLOCKED. bad_step is only flagged in ACQUIRE and LOCKED.
- Illegal sample outputs: phase_onehot=0, phase_idx holds its previous value, out_valid=1.
- rev_count increments on an ADVANCE from phase 7 to 0, in LOCKED only.
- err_count increments by 1 per flagged event and saturates at 2^ERR_W-1.
- clr_counts: zeroes both counters next cycle. If it coincides with a count event, the clear wins and the event is dropped. It does not affect the FSM.
- Reset asserted mid-operation returns everything to reset values immediately, asynchronously. The first sample after deassertion is treated as in UNLOCKED.

Test Plan:
- Reset, then feed the legal sequence from 0000, in_valid=1 every cycle -> ACQUIRE entered, then locked=1 one cycle after the 4th ADVANCE (LOCK_COUNT=4). phase_onehot shifts 01,02,04,...
- Lock, then run 3 full revolutions with in_valid toggling 1/0 -> rev_count=3, err_count=0. Outputs hold on in_valid=0 cycles.
- While locked at phase 2 (1100), inject 1010 -> illegal_code pulse, phase_onehot=00, locked=0, err_count=1. Resuming the legal sequence re-acquires.
- While locked at phase 3, inject 0011 (phase 6) -> bad_step pulse, locked drops, err_count increments. Repeat the code 1100 twice -> HOLD, no error.
- Inject 20 illegal codes with ERR_W=4 -> err_count saturates at 15. clr_counts coincident with an error -> err_count=0.
- Assert reset mid-revolution while locked -> all outputs return to reset values the same cycle, without a clk edge.
